regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Two-requester arbiter for the single write port of the 32 x 32-bit register file, built from `register32` / `register32zero` cells. It accepts write requests from two independent producers, A and B, over valid/ready handshakes and buffers one request per producer. It grants the write port round-robin and drives registered `wrenable`/address/data to the register file. Writes to register 0 are consumed but never issued, matching the hardwired-zero register.

## Interface
- `DATA_WIDTH`, 32, write data width
- `ADDR_WIDTH`, 5, register address width (32 registers)

- `clk`  input  1  clock; all state updates on posedge
- `rst_n`  input  1  asynchronous, active-low reset
- `a_valid`  input  1  requester A has a write pending
- `a_ready`  output  1  A's request is accepted at this posedge if `a_valid`
- `a_addr`  input  ADDR_WIDTH  A target register
- `a_data`  input  DATA_WIDTH  A write data
- `b_valid`, `b_ready`, `b_addr`, `b_data`: same as A, for requester B
- `wrenable`  output  1  register-file write enable (registered)
- `wraddr`  output  ADDR_WIDTH  register-file write address (registered)
- `wrdata`  output  DATA_WIDTH  register-file write data (registered)
- `last_grant`  output  1  0 = A granted most recently, 1 = B
- `busy`  output  1  either holding buffer is full

## Operation
- One holding buffer per requester: `full_x`, `addr_x`, `data_x`.
- Handshake: accept when `x_valid & x_ready` at a posedge, loading `addr_x`/`data_x` and setting `full_x`.
  - Once asserted, `x_valid` and its payload are held until accepted.
- Grant is combinational from `full_a`, `full_b` and `last_grant` only:
  - only A full: grant A
  - only B full: grant B
  - both full: grant the requester not equal to `last_grant`
  - neither full: no grant
- `x_ready = ~full_x | grant_x`. There is no combinational path from any valid to any ready.
- On a posedge with `grant_x`:
  - `full_x` clears, unless a new request is accepted on the same edge, in which case the buffer reloads and stays full.
  - `last_grant` updates to x.
  - Output registers load: `wraddr <= addr_x`, `wrdata <= data_x`, `wrenable <= (addr_x != 0)`.
- On a posedge with no grant: `wrenable <= 0`; `wraddr`/`wrdata` hold their values.
- Register-0 requests complete the handshake and consume a grant slot, but `wrenable` stays 0.
- Same address from A and B, both pending: writes issue in grant order, so the later grant wins in the register file.
- `busy = full_a | full_b`.

## Timing
- Reset (asynchronous, while `rst_n` = 0):
  - `full_a` = `full_b` = 0
  - `wrenable` = 0, `wraddr` = 0, `wrdata` = 0
  - `last_grant` = 1, so A wins the first contested grant
  - `a_ready` = `b_ready` = 1, `busy` = 0
- Latency: request accepted at edge N; `wrenable` high during cycle N+1 (after edge N+1); register file captures at edge N+2.
- Throughput:
  - one write per cycle total
  - a lone requester sustains one accept per cycle
  - under contention each requester gets every other cycle, and its `ready` drops in the cycles it is not granted
- Reset asserted mid-operation: buffered and in-flight requests are discarded; `wrenable` drops immediately (asynchronously).
- After `rst_n` deasserts, the first accept can occur at the next posedge.

## Test plan
- Reset check: drive `rst_n` = 0 mid-stream with both buffers full -> `wrenable`, `wraddr`, `wrdata` = 0 immediately; `busy` = 0; `a_ready` = `b_ready` = 1; first contested grant after reset goes to A.
- Single write: A writes addr 5, data 0xDEADBEEF at edge N -> `wrenable` = 1, `wraddr` = 5, `wrdata` = 0xDEADBEEF in cycle N+1 only; `last_grant` = 0.
- Contention: A and B hold `valid` continuously, A addrs 1,2,3, B addrs 17,18,19 -> issue order 1,17,2,18,3,19 on consecutive cycles; each `ready` alternates 1/0.
- Lone back-to-back: A streams addrs 1..8 for 8 cycles, B idle -> `a_ready` stays 1; `wrenable` high for 8 consecutive cycles with addrs 1..8.
- Zero register: B writes addr 0, data 0x12345678 -> `b_ready` handshake completes and `last_grant` = 1, but `wrenable` stays 0 that cycle; a following A write to addr 4 issues normally.
- Collision: A and B both write addr 9 (A data 0x1, B data 0x2) after reset -> A issues first, then B; final register 9 = 0x2.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single write port of the 32 x 32 register file.
// Each of the two requesters has a one-entry holding buffer; the write port outputs are registered.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  wrenable,
    output logic [ADDR_WIDTH-1:0] wraddr,
    output logic [DATA_WIDTH-1:0] wrdata,
    output logic                  last_grant,
    output logic                  busy
);

    // Handshake: a request transfers on any posedge where x_valid & x_ready.
    // x_ready depends only on buffer state and last_grant, never on any valid.
    logic                  full_a_q, full_a_d, full_b_q, full_b_d;
    logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [DATA_WIDTH-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
    logic                  last_grant_q, last_grant_d;
    logic                  wrenable_q, wrenable_d;
    logic [ADDR_WIDTH-1:0] wraddr_q, wraddr_d;
    logic [DATA_WIDTH-1:0] wrdata_q, wrdata_d;
    logic                  grant_a, grant_b, accept_a, accept_b;

    always_comb begin
        // When both buffers are full, the requester that did not win last time goes next.
        grant_a  = full_a_q & (~full_b_q | last_grant_q);
        grant_b  = full_b_q & (~full_a_q | ~last_grant_q);
        a_ready  = ~full_a_q | grant_a;
        b_ready  = ~full_b_q | grant_b;
        accept_a = a_valid & a_ready;
        accept_b = b_valid & b_ready;

        full_a_d = accept_a | (full_a_q & ~grant_a);
        full_b_d = accept_b | (full_b_q & ~grant_b);
        addr_a_d = accept_a ? a_addr : addr_a_q;
        data_a_d = accept_a ? a_data : data_a_q;
        addr_b_d = accept_b ? b_addr : addr_b_q;
        data_b_d = accept_b ? b_data : data_b_q;

        last_grant_d = last_grant_q;
        wrenable_d   = 1'b0;
        wraddr_d     = wraddr_q;
        wrdata_d     = wrdata_q;
        // Register 0 is hardwired to zero: the slot is used but no write is issued.
        if (grant_a) begin
            last_grant_d = 1'b0;
            wrenable_d   = (addr_a_q != '0);
            wraddr_d     = addr_a_q;
            wrdata_d     = data_a_q;
        end else if (grant_b) begin
            last_grant_d = 1'b1;
            wrenable_d   = (addr_b_q != '0);
            wraddr_d     = addr_b_q;
            wrdata_d     = data_b_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_a_q     <= 1'b0;
            full_b_q     <= 1'b0;
            addr_a_q     <= '0;
            data_a_q     <= '0;
            addr_b_q     <= '0;
            data_b_q     <= '0;
            last_grant_q <= 1'b1;
            wrenable_q   <= 1'b0;
            wraddr_q     <= '0;
            wrdata_q     <= '0;
        end else begin
            full_a_q     <= full_a_d;
            full_b_q     <= full_b_d;
            addr_a_q     <= addr_a_d;
            data_a_q     <= data_a_d;
            addr_b_q     <= addr_b_d;
            data_b_q     <= data_b_d;
            last_grant_q <= last_grant_d;
            wrenable_q   <= wrenable_d;
            wraddr_q     <= wraddr_d;
            wrdata_q     <= wrdata_d;
        end
    end

    assign wrenable   = wrenable_q;
    assign wraddr     = wraddr_q;
    assign wrdata     = wrdata_q;
    assign last_grant = last_grant_q;
    assign busy       = full_a_q | full_b_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: reset, a contention vector table, directed
// corner sequences and a randomized run against a queue-based reference model.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        wrenable;
    logic [4:0]  wraddr;
    logic [31:0] wrdata;
    logic        last_grant;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] rf [32];

    regfile_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_addr     (a_addr),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_addr     (b_addr),
        .b_data     (b_data),
        .wrenable   (wrenable),
        .wraddr     (wraddr),
        .wrdata     (wrdata),
        .last_grant (last_grant),
        .busy       (busy)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // register file fed by the write port
    always @(posedge clk) begin
        if (wrenable) rf[wraddr] <= wrdata;
    end

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic        bv;
        logic [4:0]  ba;
        logic        exp_ar;
        logic        exp_br;
        logic        exp_we;
        logic [4:0]  exp_wa;
        logic [31:0] exp_wd;
        logic        exp_last;
    } vec_t;

    vec_t tbl [8];

    function automatic vec_t mk(logic av, logic [4:0] aa, logic bv, logic [4:0] ba,
                                logic ar, logic br, logic we, logic [4:0] wa,
                                logic [31:0] wd, logic last);
        vec_t v;
        v.av = av; v.aa = aa; v.bv = bv; v.ba = ba;
        v.exp_ar = ar; v.exp_br = br; v.exp_we = we; v.exp_wa = wa;
        v.exp_wd = wd; v.exp_last = last;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] da(input logic [4:0] x);
        return 32'hA000_0000 | 32'(x);
    endfunction

    function automatic logic [31:0] db(input logic [4:0] x);
        return 32'hB000_0000 | 32'(x);
    endfunction

    // reference model: pending-request queues (at most one each) and the round-robin pointer
    logic [36:0] exp_a_q [$];
    logic [36:0] exp_b_q [$];

    initial begin
        rst_n = 1'b1;
        idle();

        // ---- reset mid-stream with both buffers full and a write in flight
        do_reset();
        drive(1'b1, 5'd7, 32'h7777_0007, 1'b1, 5'd8, 32'h8888_0008);
        tick();
        drive(1'b1, 5'd10, 32'h1010_1010, 1'b1, 5'd11, 32'h1111_1111);
        tick();
        chk("pre_reset_we", 32'(wrenable), 32'd1);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_we", 32'(wrenable), 32'd0);
        chk("rst_wa", 32'(wraddr), 32'd0);
        chk("rst_wd", wrdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ar", 32'(a_ready), 32'd1);
        chk("rst_br", 32'(b_ready), 32'd1);
        chk("rst_last", 32'(last_grant), 32'd1);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 5'd12, 32'h0000_000C, 1'b1, 5'd13, 32'h0000_000D);
        tick();
        chk("post_rst_we0", 32'(wrenable), 32'd0);
        idle();
        tick();
        chk("post_rst_first_grant_a", 32'(wraddr), 32'd12);
        chk("post_rst_last", 32'(last_grant), 32'd0);
        tick();
        chk("post_rst_second_b", 32'(wraddr), 32'd13);

        // ---- contention table: A 1,2,3 and B 17,18,19 held continuously
        tbl[0] = mk(1, 1, 1, 17, 1, 1, 0, 0,  32'd0,  1);
        tbl[1] = mk(1, 2, 1, 18, 1, 0, 1, 1,  da(1),  0);
        tbl[2] = mk(1, 2, 1, 18, 0, 1, 1, 17, db(17), 1);
        tbl[3] = mk(1, 3, 1, 19, 1, 0, 1, 2,  da(2),  0);
        tbl[4] = mk(0, 0, 1, 19, 0, 1, 1, 18, db(18), 1);
        tbl[5] = mk(0, 0, 0, 0,  1, 0, 1, 3,  da(3),  0);
        tbl[6] = mk(0, 0, 0, 0,  1, 1, 1, 19, db(19), 1);
        tbl[7] = mk(0, 0, 0, 0,  1, 1, 0, 19, db(19), 1);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].av, tbl[i].aa, da(tbl[i].aa), tbl[i].bv, tbl[i].ba, db(tbl[i].ba));
            #1;
            chk($sformatf("tbl%0d_ar", i), 32'(a_ready), 32'(tbl[i].exp_ar));
            chk($sformatf("tbl%0d_br", i), 32'(b_ready), 32'(tbl[i].exp_br));
            tick();
            chk($sformatf("tbl%0d_we", i), 32'(wrenable), 32'(tbl[i].exp_we));
            chk($sformatf("tbl%0d_wa", i), 32'(wraddr), 32'(tbl[i].exp_wa));
            chk($sformatf("tbl%0d_wd", i), wrdata, tbl[i].exp_wd);
            chk($sformatf("tbl%0d_last", i), 32'(last_grant), 32'(tbl[i].exp_last));
        end

        // ---- single write
        do_reset();
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
        tick();
        chk("single_we_n", 32'(wrenable), 32'd0);
        idle();
        tick();
        chk("single_we_n1", 32'(wrenable), 32'd1);
        chk("single_wa", 32'(wraddr), 32'd5);
        chk("single_wd", wrdata, 32'hDEAD_BEEF);
        chk("single_last", 32'(last_grant), 32'd0);
        tick();
        chk("single_we_n2", 32'(wrenable), 32'd0);
        chk("single_wa_hold", 32'(wraddr), 32'd5);

        // ---- lone back-to-back stream from A
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            if (k <= 8) drive(1'b1, 5'(k), 32'h5500_0000 + 32'(k), 1'b0, 5'd0, 32'd0);
            else idle();
            #1;
            if (k <= 8) chk($sformatf("lone%0d_ar", k), 32'(a_ready), 32'd1);
            tick();
            if (k >= 2) begin
                chk($sformatf("lone%0d_we", k), 32'(wrenable), 32'd1);
                chk($sformatf("lone%0d_wa", k), 32'(wraddr), 32'(k - 1));
            end
        end
        idle();
        tick();
        chk("lone_end_we", 32'(wrenable), 32'd0);

        // ---- zero register from B, then A to addr 4
        do_reset();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234_5678);
        #1;
        chk("zero_br", 32'(b_ready), 32'd1);
        tick();
        drive(1'b1, 5'd4, 32'h0000_0444, 1'b0, 5'd0, 32'd0);
        tick();
        chk("zero_we", 32'(wrenable), 32'd0);
        chk("zero_last", 32'(last_grant), 32'd1);
        chk("zero_busy", 32'(busy), 32'd1);
        idle();
        tick();
        chk("zero_next_we", 32'(wrenable), 32'd1);
        chk("zero_next_wa", 32'(wraddr), 32'd4);
        chk("zero_next_wd", wrdata, 32'h0000_0444);

        // ---- collision on addr 9
        do_reset();
        drive(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h2);
        tick();
        idle();
        tick();
        chk("coll_first_wd", wrdata, 32'h1);
        tick();
        chk("coll_second_wd", wrdata, 32'h2);
        tick();
        chk("coll_rf9", rf[9], 32'h2);

        // ---- randomized run against the reference model
        do_reset();
        begin
            logic        last_m;
            logic        av, bv, pend_a, pend_b, rdy_a, rdy_b, acc_a, acc_b;
            logic [4:0]  aa, ba, ew_a;
            logic [31:0] ad, bd, ew_d;
            logic        ew_e;
            logic [36:0] ent;
            int          win;
            last_m = 1'b1; pend_a = 1'b0; pend_b = 1'b0;
            ew_e = 1'b0; ew_a = 5'd0; ew_d = 32'd0;
            av = 1'b0; bv = 1'b0; aa = 5'd0; ba = 5'd0; ad = 32'd0; bd = 32'd0;
            exp_a_q.delete();
            exp_b_q.delete();
            for (int c = 0; c < 400; c++) begin
                if (!pend_a) begin
                    av = ($urandom_range(0, 99) < 60);
                    aa = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    ad = $urandom;
                end
                if (!pend_b) begin
                    bv = ($urandom_range(0, 99) < 60);
                    ba = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    bd = $urandom;
                end
                drive(av, aa, ad, bv, ba, bd);
                if (exp_a_q.size() != 0 && exp_b_q.size() != 0) win = last_m ? 1 : 2;
                else if (exp_a_q.size() != 0) win = 1;
                else if (exp_b_q.size() != 0) win = 2;
                else win = 0;
                rdy_a = (exp_a_q.size() == 0) || (win == 1);
                rdy_b = (exp_b_q.size() == 0) || (win == 2);
                #1;
                chk("rnd_ar", 32'(a_ready), 32'(rdy_a));
                chk("rnd_br", 32'(b_ready), 32'(rdy_b));
                chk("rnd_busy", 32'(busy), 32'(exp_a_q.size() != 0 || exp_b_q.size() != 0));
                acc_a = av & rdy_a;
                acc_b = bv & rdy_b;
                ew_e = 1'b0;
                if (win == 1) begin
                    ent = exp_a_q.pop_front();
                    last_m = 1'b0;
                end else if (win == 2) begin
                    ent = exp_b_q.pop_front();
                    last_m = 1'b1;
                end
                if (win != 0) begin
                    ew_a = ent[36:32];
                    ew_d = ent[31:0];
                    ew_e = (ent[36:32] != 5'd0);
                end
                if (acc_a) exp_a_q.push_back({aa, ad});
                if (acc_b) exp_b_q.push_back({ba, bd});
                pend_a = av & ~acc_a;
                pend_b = bv & ~acc_b;
                tick();
                chk("rnd_we", 32'(wrenable), 32'(ew_e));
                chk("rnd_wa", 32'(wraddr), 32'(ew_a));
                chk("rnd_wd", wrdata, ew_d);
                chk("rnd_last", 32'(last_grant), 32'(last_m));
            end
        end

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
